majority_vote_sequencer: RTL
============================

// Module: majority_vote_sequencer
// PURPOSE
//  Sequences an N-input majority decision over a serial vote stream.
//  Collects exactly N single-bit votes through a valid/ready handshake, counts the ones,
//  and presents the majority result plus tie and count through a result handshake.
//  Sits between vote producers (one vote per cycle max) and the consumer of the decision.
// PARAMETERS
//  N   8              number of votes per decision, N >= 1
//  CW  $clog2(N+1)    width of the ones counter and vote index
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   begin a decision; honoured only in IDLE
//  abort         in   1   discard the decision in progress; honoured only in COLLECT
//  vote_valid    in   1   vote_bit is valid this cycle
//  vote_bit      in   1   vote value
//  vote_ready    out  1   block accepts a vote this cycle
//  busy          out  1   state != IDLE
//  result_valid  out  1   result, tie and ones_count are valid
//  result_ready  in   1   consumer takes the result
//  result        out  1   majority: 1 iff 2*ones_count > N
//  tie           out  1   2*ones_count == N (even N only; constant 0 for odd N)
//  ones_count    out  CW  number of 1-votes in the completed decision
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; every output and internal counter = 0.
//  States: IDLE, COLLECT, REPORT; all state and outputs are registered.
//  IDLE:
//   - vote_ready=0, result_valid=0.
//   - start=1 -> COLLECT; clear vote index and ones counter.
//   - abort in IDLE is ignored.
//  COLLECT:
//   - vote_ready=1.
//   - Accept on vote_valid&vote_ready: index+=1, count+=vote_bit.
//   - When the Nth vote is accepted -> REPORT. result, tie and ones_count are
//     registered on that edge, so result_valid rises the cycle after the Nth acceptance.
//   - vote_valid=0 cycles stall with no timeout.
//   - abort=1 -> IDLE and discard partial counts; a vote presented in the same cycle is
//     not accepted and vote_ready is still 1 in that cycle. Abort wins over the Nth vote.
//   - start is ignored.
//  REPORT:
//   - vote_ready=0; result_valid=1.
//   - result, tie and ones_count are held stable until result_ready=1, then -> IDLE.
//   - On the exit edge result_valid drops and result, tie and ones_count clear to 0.
//   - start and abort are ignored.
//  Throughput: at most one decision per N+2 cycles (start, N votes, report).
//  Width rules:
//   - The count never exceeds N, so no overflow.
//   - Comparisons use 2*count vs N at CW+1 bits.
//  Reset mid-operation: immediate return to IDLE with outputs 0; no partial result is emitted.
// STRUCTURE
//  Package majority_pkg:
//   - state enum {IDLE, COLLECT, REPORT}
//   - function cnt_width(n) = $clog2(n+1)
//  Sub-module majority_decide: combinational (count, N) -> (result, tie).
//  FSM and counters stay in this module.
// TESTING (N=8 unless stated)
//  1. Reset:
//     rst_n low mid-COLLECT after 5 votes -> all outputs 0 at once; next start gives a fresh
//     count.
//  2. Majority: start, votes 1,1,1,1,1,0,0,0 back-to-back ->
//     result_valid the cycle after the 8th vote; result=1, tie=0, ones_count=5.
//  3. Tie:
//     votes 1,0,1,0,1,0,1,0 with vote_valid gaps -> result=0, tie=1, ones_count=4.
//     With N=7, votes 1,1,1,0,0,0,0 -> result=0, tie=0, ones_count=3.
//  4. Backpressure:
//     hold result_ready=0 for 10 cycles -> outputs stable and vote_ready=0.
//     Extra vote_valid pulses are not counted.
//     The release cycle returns to IDLE.
//  5. Abort:
//     abort together with the 8th vote -> IDLE, no result_valid pulse.
//     Next decision of all 1s -> ones_count=8, result=1.
//  6. Exhaustive:
//     sweep all 256 8-bit vote patterns -> result == (popcount>4) and tie == (popcount==4)
//     against a reference model.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared types and helpers for the majority vote sequencer.
// State encoding and the counter width rule live here so all files agree.
package majority_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_e;

  // Bits needed to hold any value 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/majority_decide.sv
// Combinational majority/tie decision for a ones count out of N votes.
// The compare runs at CW+1 bits so doubling the count cannot overflow.
module majority_decide
  import majority_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cnt_width(N)
) (
  input  logic [CW-1:0] count,
  output logic          result,
  output logic          tie
);

  logic [CW:0] twice;
  logic [CW:0] n_ext;

  assign twice  = {count, 1'b0};
  assign n_ext  = (CW + 1)'(N);
  assign result = (twice > n_ext);

  // An odd vote total can never split evenly.
  generate
    if ((N % 2) == 0) begin : g_even
      assign tie = (twice == n_ext);
    end else begin : g_odd
      assign tie = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/majority_vote_sequencer.sv
// Collects N serial votes over a valid/ready handshake and reports the
// majority, tie flag and ones count through a held result handshake.
module majority_vote_sequencer
  import majority_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          vote_valid,
  input  logic          vote_bit,
  output logic          vote_ready,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          result,
  output logic          tie,
  output logic [CW-1:0] ones_count
);

  state_e          state_q;
  logic [CW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic            vote_ready_q;
  logic            busy_q;
  logic            result_valid_q;
  logic            result_q;
  logic            tie_q;
  logic [CW-1:0]   ones_q;

  logic [CW-1:0]   idx_d;
  logic [CW-1:0]   cnt_d;
  logic            accept;
  logic            last_vote;
  logic            dec_result;
  logic            dec_tie;

  assign accept    = vote_valid && vote_ready_q;
  assign idx_d     = idx_q + CW'(1);
  assign cnt_d     = cnt_q + CW'(vote_bit);
  assign last_vote = (idx_q == CW'(N - 1));

  // Decide on the count including the vote being accepted this cycle,
  // so the result can be registered on the same edge as the Nth vote.
  majority_decide #(
    .N  (N),
    .CW (CW)
  ) u_decide (
    .count  (cnt_d),
    .result (dec_result),
    .tie    (dec_tie)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      vote_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= 1'b0;
      tie_q          <= 1'b0;
      ones_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= COLLECT;
            idx_q        <= '0;
            cnt_q        <= '0;
            vote_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end

        COLLECT: begin
          // Abort takes priority, including over a final vote in the same cycle.
          if (abort) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            vote_ready_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (accept) begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            if (last_vote) begin
              state_q        <= REPORT;
              vote_ready_q   <= 1'b0;
              result_valid_q <= 1'b1;
              result_q       <= dec_result;
              tie_q          <= dec_tie;
              ones_q         <= cnt_d;
            end
          end
        end

        REPORT: begin
          if (result_ready) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= 1'b0;
            tie_q          <= 1'b0;
            ones_q         <= '0;
          end
        end

        default: begin
          state_q        <= IDLE;
          idx_q          <= '0;
          cnt_q          <= '0;
          vote_ready_q   <= 1'b0;
          busy_q         <= 1'b0;
          result_valid_q <= 1'b0;
          result_q       <= 1'b0;
          tie_q          <= 1'b0;
          ones_q         <= '0;
        end
      endcase
    end
  end

  assign vote_ready   = vote_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign tie          = tie_q;
  assign ones_count   = ones_q;

endmodule
